// File: rtl/rename_pkg.sv
// Shared widths and types for the rename-aware register file.
package rename_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int ROB_WIDTH  = 4;
    localparam int NREG_IDX_W = $clog2(NREG);

    typedef logic [NREG_IDX_W-1:0] reg_idx_t;
    typedef logic [ROB_WIDTH-1:0]  rob_tag_t;
    typedef logic [XLEN-1:0]       data_t;

endpackage

// File: rtl/commit_match.sv
// Compares one producer tag against every active commit port and returns the
// value of the youngest (highest-index) matching port.
module commit_match
    import rename_pkg::*;
#(
    parameter int TAG_W      = ROB_WIDTH,
    parameter int DATA_W     = XLEN,
    parameter int NUM_COMMIT = 2
) (
    input  logic [TAG_W-1:0]             tag_i,
    input  logic [NUM_COMMIT-1:0]        commit_valid_i,
    input  logic [NUM_COMMIT*TAG_W-1:0]  commit_tag_i,
    input  logic [NUM_COMMIT*DATA_W-1:0] commit_value_i,
    output logic                         hit_o,
    output logic [DATA_W-1:0]            value_o
);

    // Scan ports oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit_o   = 1'b0;
        value_o = '0;
        for (int c = 0; c < NUM_COMMIT; c++) begin
            if (commit_valid_i[c] && (commit_tag_i[c*TAG_W +: TAG_W] == tag_i)) begin
                hit_o   = 1'b1;
                value_o = commit_value_i[c*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/register_file_rename.sv
// Rename-aware architectural register file: combinational operand reads with
// commit forwarding, one destination rename per cycle, multi-port commit,
// flush of all pending renames and a registered busy-register counter.
module register_file_rename #(
    parameter int XLEN       = rename_pkg::XLEN,
    parameter int NREG       = rename_pkg::NREG,
    parameter int ROB_WIDTH  = rename_pkg::ROB_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int NUM_COMMIT = 2
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            rdy_in,
    input  logic                            issue_valid,
    input  logic [$clog2(NREG)-1:0]         issue_rd,
    input  logic [ROB_WIDTH-1:0]            issue_tag,
    input  logic [NUM_READ*$clog2(NREG)-1:0] rs_id,
    output logic [NUM_READ*XLEN-1:0]        rs_value,
    output logic [NUM_READ*ROB_WIDTH-1:0]   rs_tag,
    output logic [NUM_READ-1:0]             rs_valid,
    input  logic [NUM_COMMIT-1:0]           commit_valid,
    input  logic [NUM_COMMIT*ROB_WIDTH-1:0] commit_tag,
    input  logic [NUM_COMMIT*XLEN-1:0]      commit_value,
    input  logic                            flush,
    output logic [$clog2(NREG):0]           busy_count
);

    localparam int IW = $clog2(NREG);
    localparam int CW = IW + 1;

    // Architectural state; entry 0 is never written and stays at its reset value.
    logic [XLEN-1:0]      value_q [NREG];
    logic [XLEN-1:0]      value_d [NREG];
    logic [ROB_WIDTH-1:0] tag_q   [NREG];
    logic [ROB_WIDTH-1:0] tag_d   [NREG];
    logic [NREG-1:0]      busy_q;
    logic [NREG-1:0]      busy_d;
    logic [CW-1:0]        busy_count_q;
    logic [CW-1:0]        busy_count_d;

    // Per-register commit match results used by the state update.
    logic [NREG-1:0]      st_hit;
    logic [XLEN-1:0]      st_value [NREG];

    int unsigned          n_set;
    int unsigned          n_clr;

    // ---------------------------------------------------------------------
    // Read ports: not busy -> stored value; busy -> forward a same-cycle
    // commit of the producer tag if there is one, otherwise wait on the tag.
    // A rename issued this cycle is deliberately not visible here.
    // ---------------------------------------------------------------------
    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [IW-1:0]   id;
        logic            fwd_hit;
        logic [XLEN-1:0] fwd_value;

        assign id = rs_id[p*IW +: IW];

        commit_match #(
            .TAG_W      (ROB_WIDTH),
            .DATA_W     (XLEN),
            .NUM_COMMIT (NUM_COMMIT)
        ) u_fwd (
            .tag_i          (tag_q[id]),
            .commit_valid_i (commit_valid),
            .commit_tag_i   (commit_tag),
            .commit_value_i (commit_value),
            .hit_o          (fwd_hit),
            .value_o        (fwd_value)
        );

        assign rs_valid[p]                       = !busy_q[id] || fwd_hit;
        assign rs_value[p*XLEN +: XLEN]          = (busy_q[id] && fwd_hit) ? fwd_value : value_q[id];
        assign rs_tag[p*ROB_WIDTH +: ROB_WIDTH]  = tag_q[id];
    end

    // Register 0 never waits on a producer.
    assign st_hit[0]   = 1'b0;
    assign st_value[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_state
        commit_match #(
            .TAG_W      (ROB_WIDTH),
            .DATA_W     (XLEN),
            .NUM_COMMIT (NUM_COMMIT)
        ) u_cm (
            .tag_i          (tag_q[r]),
            .commit_valid_i (commit_valid),
            .commit_tag_i   (commit_tag),
            .commit_value_i (commit_value),
            .hit_o          (st_hit[r]),
            .value_o        (st_value[r])
        );
    end

    // Next state: commits write values and release, then flush clears every
    // busy bit or a rename re-arms its destination with the new tag.
    always_comb begin
        busy_d       = busy_q;
        busy_count_d = busy_count_q;
        n_set        = 0;
        n_clr        = 0;
        for (int r = 0; r < NREG; r++) begin
            value_d[r] = value_q[r];
            tag_d[r]   = tag_q[r];
        end

        if (rdy_in) begin
            for (int r = 1; r < NREG; r++) begin
                if (busy_q[r] && st_hit[r]) begin
                    value_d[r] = st_value[r];
                    busy_d[r]  = 1'b0;
                end
                if (flush) begin
                    busy_d[r] = 1'b0;
                end else if (issue_valid && (issue_rd == IW'(r))) begin
                    tag_d[r]  = issue_tag;
                    busy_d[r] = 1'b1;
                end
            end
        end

        for (int r = 0; r < NREG; r++) begin
            if (busy_q[r] && !busy_d[r]) n_clr = n_clr + 1;
            if (!busy_q[r] && busy_d[r]) n_set = n_set + 1;
        end

        if (rdy_in) begin
            if (flush) begin
                busy_count_d = '0;
            end else begin
                busy_count_d = busy_count_q + CW'(n_set) - CW'(n_clr);
            end
        end
    end

    // State registers with asynchronous return to the all-zero reset state.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int r = 0; r < NREG; r++) begin
                value_q[r] <= '0;
                tag_q[r]   <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                value_q[r] <= value_d[r];
                tag_q[r]   <= tag_d[r];
            end
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

    // ---------------------------------------------------------------------
    // Invariants: the incremental counter tracks the busy bits exactly, and
    // no two busy registers share a producer tag.
    // ---------------------------------------------------------------------
    function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NREG; i++) n = n + int'(v[i]);
        return CW'(n);
    endfunction

    logic alias_err;

    // Pairwise tag comparison across busy registers.
    always_comb begin
        alias_err = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            for (int j = i + 1; j < NREG; j++) begin
                if (busy_q[i] && busy_q[j] && (tag_q[i] == tag_q[j])) alias_err = 1'b1;
            end
        end
    end

    a_busy_count : assert property (@(posedge clk_in) disable iff (!rst_n_in)
        busy_count_q == popcount(busy_q));

    a_no_alias : assert property (@(posedge clk_in) disable iff (!rst_n_in)
        !alias_err);

endmodule

// File: doc/register_file_rename.md
Name: register_file_rename

Overview:
- Parametrised rename-aware architectural register file for the out-of-order core. Sits between the issue stage and the ROB.
- Issue reads NUM_READ source operands (value, tag, valid) and renames one destination to a ROB tag.
- ROB retires up to NUM_COMMIT results per cycle with same-cycle forwarding.
- Adds over the previous generation: multiple commit ports, a flush input that discards all pending tags on misprediction, and a busy-register counter.

Parameters:
XLEN, 32, register data width
NREG, 32, number of architectural registers (power of 2, ≥2; register 0 hardwired to zero)
ROB_WIDTH, 4, ROB tag width
NUM_READ, 2, source operand read ports
NUM_COMMIT, 2, commit ports (1..4); higher index = younger in program order

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  ready; state frozen when low
issue_valid  input  1  rename rd this cycle
issue_rd  input  $clog2(NREG)  destination register
issue_tag  input  ROB_WIDTH  ROB tag assigned to rd
rs_id  input  NUM_READ*$clog2(NREG)  packed source register ids
rs_value  output  NUM_READ*XLEN  packed operand values
rs_tag  output  NUM_READ*ROB_WIDTH  packed producer tags
rs_valid  output  NUM_READ  1 = value usable, 0 = wait on rs_tag
commit_valid  input  NUM_COMMIT  per-port commit strobe
commit_tag  input  NUM_COMMIT*ROB_WIDTH  packed committing tags
commit_value  input  NUM_COMMIT*XLEN  packed committing values
flush  input  1  misprediction: drop all pending renames
busy_count  output  $clog2(NREG)+1  number of registers currently awaiting a tag

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-low on rst_n_in.
- Reset state: all values = 0, tags = 0, busy = 0, busy_count = 0.
  - With rs_id = 0 after reset: rs_value = 0, rs_tag = 0, rs_valid = 1.
- Per-register state: value[XLEN], tag[ROB_WIDTH], busy.
- rdy_in low: no state changes (issue, commit and flush all ignored). Read outputs stay combinational.
- Register 0: never busy; value always 0. Issue and commit targeting reg 0 are ignored.
- Read path (combinational, zero latency), per read port p on reg r:
  - Not busy: value[r], valid = 1, tag = tag[r].
  - Busy and some commit port c has commit_valid[c] with commit_tag[c] == tag[r]: forward commit_value of the highest such c, valid = 1.
  - Otherwise: valid = 0, tag = tag[r], value = value[r] (don't-care).
  - Read does not see a same-cycle issue rename (issue stage handles intra-bundle dependency).
- Commit (posedge, rdy_in):
  - For each reg r ≠ 0 that is busy with tag[r] matching an active commit port: value[r] <= that port's value.
    - Multiple matching ports: highest index wins.
  - busy[r] cleared unless issue_valid renames r in the same cycle. In that case busy stays 1 with issue_tag, and the committed value is still written.
- Issue (posedge, rdy_in, issue_valid, issue_rd ≠ 0): tag <= issue_tag, busy <= 1. Overrides any prior pending tag.
- Flush (posedge, rdy_in):
  - All busy bits cleared. Commits in the same cycle are applied to values first.
  - Same-cycle issue is ignored. Tags are left unchanged (don't-care while not busy).
- busy_count:
  - Registered. Equals popcount(busy) after each edge.
  - Updated incrementally: +1 for issue on a non-busy reg, −k for k regs released, 0 on flush.
  - Never negative and never exceeds NREG−1; an assertion checks it against the popcount.
- Tag aliasing: at most one register holds a given busy tag. The ROB guarantees this; an assertion checks it.
- Reset mid-operation: immediate return to the reset state regardless of clock or rdy_in.

Decomposition:
- Shared package rename_pkg: XLEN, ROB_WIDTH, NREG_IDX_W = $clog2(NREG), and typedefs reg_idx_t, rob_tag_t, data_t.
- One sub-module, commit_match: given a tag, returns hit plus the highest-index matching commit value.
  - Instantiated NUM_READ times for forwarding and NREG−1 times for state update.

Test Plan:
- Reset, then read x0 and x5 → rs_value = 0/0, rs_valid = 1/1, busy_count = 0. Issue x5 with tag 3 (~x5 not busy) → next cycle rs_valid(x5) = 0, rs_tag = 3, busy_count = 1.
- x5 busy on tag 3; commit port 0 tag 3 value 0xDEADBEEF while reading x5 → same cycle rs_value = 0xDEADBEEF, rs_valid = 1. Next cycle x5 not busy, busy_count = 0.
- Issue x7 tag 2 in the same cycle that commit tag 1 (x7's old tag) value 0x55 → x7 value = 0x55, busy = 1, tag = 2, busy_count unchanged.
- x3 busy tag 4, x9 busy tag 6; commit ports 0/1 with tags 4/6, values 0x10/0x20 → both released, busy_count −2. Then both ports carry tag 6 (same reg) → port 1 value selected.
- x1, x2, x4 busy (busy_count = 3); flush with commit tag(x2) value 0x99 and issue x8 → all not busy, x2 = 0x99, x8 not renamed, busy_count = 0.
- rdy_in low during issue/commit/flush → no state change. Assert rst_n_in mid-cycle → outputs return to reset values asynchronously.
